// File: rtl/ifu_defs.sv
// Shared definitions for the IFU next-PC scheduler: reset/exception address
// defaults, redirect FSM states and next-PC select codes.
package ifu_defs;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } pend_state_e;

  typedef enum logic [2:0] {
    SEL_SEQ  = 3'd0,
    SEL_BR   = 3'd1,
    SEL_PEND = 3'd2,
    SEL_ERET = 3'd3,
    SEL_EXC  = 3'd4
  } npc_sel_e;

endpackage

// File: rtl/ifu_npc_mux.sv
// Next-PC selector: maps a select code onto the candidate next-PC values.
module ifu_npc_mux
  import ifu_defs::*;
#(
  parameter logic [31:0] EXC_VEC = EXC_VEC_DEF
) (
  input  logic [2:0]  sel,
  input  logic [31:0] pc,
  input  logic [31:0] br_target,
  input  logic [31:0] pend_tgt,
  input  logic [31:0] epc,
  output logic [31:0] npc
);

  always_comb begin
    npc = pc + 32'd4;
    case (sel)
      SEL_BR:   npc = br_target;
      SEL_PEND: npc = pend_tgt;
      SEL_ERET: npc = epc;
      SEL_EXC:  npc = EXC_VEC;
      default:  npc = pc + 32'd4;
    endcase
  end

endmodule

// File: rtl/ifu_npc_sched.sv
// IFU next-PC scheduler: priority next-PC selection, stalled-redirect latch and
// saturating stall counter. Exception/ERET support is enabled by IFU_EXC_EN.
module ifu_npc_sched
  import ifu_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic [31:0]      PC,
  input  logic             STALL,
  input  logic             BR_TAKEN,
  input  logic [31:0]      BR_TARGET,
  input  logic             EXC_REQ,
  input  logic             ERET_REQ,
  input  logic [31:0]      EPC,
  output logic [31:0]      D,
  output logic             STALL_EN_N,
  output logic             REDIR_PEND,
  output logic             FLUSH_IF,
  output logic [CNT_W-1:0] STALL_CNT
);

  pend_state_e      state_q, state_d;
  logic [31:0]      pend_tgt_q, pend_tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  npc_sel_e         sel;
  logic [31:0]      npc;
  logic             exc, eret, hold;

`ifdef IFU_EXC_EN
  assign exc  = EXC_REQ;
  assign eret = ERET_REQ;
`else
  logic unused_exc_inputs;
  assign unused_exc_inputs = EXC_REQ ^ ERET_REQ;
  assign exc  = 1'b0;
  assign eret = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    pend_tgt_d = pend_tgt_q;
    cnt_d      = cnt_q;
    hold       = STALL & ~exc & ~eret;

    if (exc)                 sel = SEL_EXC;
    else if (eret)           sel = SEL_ERET;
    else if (state_q == PEND) sel = SEL_PEND;
    else if (BR_TAKEN)       sel = SEL_BR;
    else                     sel = SEL_SEQ;

    // A duplicate BR_TAKEN while PEND is ignored: the ID stage is frozen.
    case (state_q)
      IDLE: begin
        if (BR_TAKEN && hold) begin
          state_d    = PEND;
          pend_tgt_d = BR_TARGET;
        end
      end
      PEND: begin
        if (exc || eret || !STALL) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hold && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q    <= IDLE;
      pend_tgt_q <= '0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_tgt_q <= pend_tgt_d;
      cnt_q      <= cnt_d;
    end
  end

  ifu_npc_mux #(.EXC_VEC(EXC_VEC)) u_mux (
    .sel       (sel),
    .pc        (PC),
    .br_target (BR_TARGET),
    .pend_tgt  (pend_tgt_q),
    .epc       (EPC),
    .npc       (npc)
  );

  // Reset forces the PC register to load RESET_PC on every reset edge.
  assign D          = RESET ? RESET_PC : npc;
  assign STALL_EN_N = RESET ? 1'b0 : hold;
  assign REDIR_PEND = RESET ? 1'b0 : (state_q == PEND);
  assign FLUSH_IF   = RESET ? 1'b0 : (exc | eret);
  assign STALL_CNT  = cnt_q;

endmodule

// File: tb/tb_ifu_npc_sched.sv
// Self-checking bench for ifu_npc_sched: directed table, exception/ERET and
// wrap/saturation sequences, then randomized traffic against a reference model.
module tb_ifu_npc_sched;

`ifdef IFU_EXC_EN
  localparam bit EXC_ON = 1'b1;
`else
  localparam bit EXC_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        RESET, STALL, BR_TAKEN, EXC_REQ, ERET_REQ;
  logic [31:0] PC, BR_TARGET, EPC;
  logic [31:0] D, D_s;
  logic        STALL_EN_N, REDIR_PEND, FLUSH_IF;
  logic        STALL_EN_N_s, REDIR_PEND_s, FLUSH_IF_s;
  logic [31:0] STALL_CNT;
  logic [3:0]  STALL_CNT_s;

  always #5 clk = ~clk;

  ifu_npc_sched dut (
    .clk(clk), .RESET(RESET), .PC(PC), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .EXC_REQ(EXC_REQ), .ERET_REQ(ERET_REQ), .EPC(EPC),
    .D(D), .STALL_EN_N(STALL_EN_N), .REDIR_PEND(REDIR_PEND), .FLUSH_IF(FLUSH_IF),
    .STALL_CNT(STALL_CNT)
  );

  ifu_npc_sched #(.CNT_W(4)) dut_s (
    .clk(clk), .RESET(RESET), .PC(PC), .STALL(STALL), .BR_TAKEN(BR_TAKEN),
    .BR_TARGET(BR_TARGET), .EXC_REQ(EXC_REQ), .ERET_REQ(ERET_REQ), .EPC(EPC),
    .D(D_s), .STALL_EN_N(STALL_EN_N_s), .REDIR_PEND(REDIR_PEND_s), .FLUSH_IF(FLUSH_IF_s),
    .STALL_CNT(STALL_CNT_s)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: PC register, queue of at most one pending target, stall count.
  logic [31:0]     m_pc = 32'h0;
  logic [31:0]     m_pend[$];
  longint unsigned m_cnt = 0;
  bit              m_cnt_ok = 1'b0;
  localparam longint unsigned CNT_MAX = 64'hFFFF_FFFF;

  logic [31:0] s_d, s_cnt;
  logic        s_sen, s_rp, s_flush;
  logic [3:0]  s_cnt_s;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cycle(input bit rst, input bit st, input bit br, input logic [31:0] tgt,
                       input bit ex, input bit er, input logic [31:0] epc);
    bit          e_ex, e_er, e_sen, e_rp, e_fl;
    logic [31:0] e_d;
    longint unsigned e_small;
    RESET = rst; STALL = st; BR_TAKEN = br; BR_TARGET = tgt;
    EXC_REQ = ex; ERET_REQ = er; EPC = epc; PC = m_pc;
    @(negedge clk);
    e_ex = EXC_ON & ex;
    e_er = EXC_ON & er;
    if (rst) begin
      e_d = 32'h0000_3000; e_sen = 0; e_rp = 0; e_fl = 0;
    end else begin
      e_rp  = (m_pend.size() != 0);
      e_sen = st && !e_ex && !e_er;
      e_fl  = e_ex || e_er;
      if (e_ex)       e_d = 32'h0000_4180;
      else if (e_er)  e_d = epc;
      else if (e_rp)  e_d = m_pend[0];
      else if (br)    e_d = tgt;
      else            e_d = m_pc + 32'd4;
    end
    s_d = D; s_sen = STALL_EN_N; s_rp = REDIR_PEND; s_flush = FLUSH_IF;
    s_cnt = STALL_CNT; s_cnt_s = STALL_CNT_s;
    chk("m_d", D, e_d);
    chk("m_stall_en_n", {31'b0, STALL_EN_N}, {31'b0, e_sen});
    chk("m_redir_pend", {31'b0, REDIR_PEND}, {31'b0, e_rp});
    chk("m_flush_if", {31'b0, FLUSH_IF}, {31'b0, e_fl});
    chk("m_d_small", D_s, e_d);
    if (m_cnt_ok) begin
      e_small = (m_cnt > 15) ? 15 : m_cnt;
      chk("m_stall_cnt", STALL_CNT, m_cnt[31:0]);
      chk("m_stall_cnt4", {28'b0, STALL_CNT_s}, e_small[31:0]);
    end
    @(posedge clk);
    if (rst) begin
      m_pend.delete(); m_cnt = 0; m_cnt_ok = 1'b1; m_pc = e_d;
    end else begin
      if (!e_sen) m_pc = e_d;
      if (e_ex || e_er)                      m_pend.delete();
      else if (m_pend.size() != 0 && !st)    m_pend.delete();
      else if (m_pend.size() == 0 && br && st) m_pend.push_back(tgt);
      if (e_sen && m_cnt < CNT_MAX) m_cnt++;
    end
    #1;
  endtask

  typedef struct {
    bit rst, st, br; logic [31:0] tgt;
    logic [31:0] d; bit sen, rp, ck_cnt; logic [31:0] cnt;
  } vec_t;
  vec_t tbl[16];

  initial begin
    RESET = 1; STALL = 0; BR_TAKEN = 0; EXC_REQ = 0; ERET_REQ = 0;
    BR_TARGET = 0; EPC = 0; PC = 0;
    #1;
    //          rst st br tgt            d              sen rp ck cnt
    tbl[0]  = '{1, 0, 0, 32'h0,      32'h0000_3000, 0, 0, 0, 32'd0};
    tbl[1]  = '{1, 0, 0, 32'h0,      32'h0000_3000, 0, 0, 1, 32'd0};
    tbl[2]  = '{0, 0, 0, 32'h0,      32'h0000_3004, 0, 0, 1, 32'd0};
    tbl[3]  = '{0, 0, 0, 32'h0,      32'h0000_3008, 0, 0, 1, 32'd0};
    tbl[4]  = '{0, 0, 0, 32'h0,      32'h0000_300C, 0, 0, 1, 32'd0};
    tbl[5]  = '{0, 0, 0, 32'h0,      32'h0000_3010, 0, 0, 1, 32'd0};
    tbl[6]  = '{0, 0, 1, 32'h3100,   32'h0000_3100, 0, 0, 1, 32'd0};
    tbl[7]  = '{0, 0, 0, 32'h0,      32'h0000_3104, 0, 0, 1, 32'd0};
    tbl[8]  = '{0, 1, 1, 32'h3200,   32'h0000_3200, 1, 0, 1, 32'd0};
    tbl[9]  = '{0, 1, 0, 32'h0,      32'h0000_3200, 1, 1, 1, 32'd1};
    tbl[10] = '{0, 1, 0, 32'h0,      32'h0000_3200, 1, 1, 1, 32'd2};
    tbl[11] = '{0, 0, 0, 32'h0,      32'h0000_3200, 0, 1, 1, 32'd3};
    tbl[12] = '{0, 0, 0, 32'h0,      32'h0000_3204, 0, 0, 1, 32'd3};
    tbl[13] = '{0, 1, 1, 32'h3300,   32'h0000_3300, 1, 0, 1, 32'd3};
    tbl[14] = '{1, 1, 0, 32'h0,      32'h0000_3000, 0, 0, 1, 32'd4};
    tbl[15] = '{0, 0, 0, 32'h0,      32'h0000_3004, 0, 0, 1, 32'd0};
    for (int i = 0; i < 16; i++) begin
      cycle(tbl[i].rst, tbl[i].st, tbl[i].br, tbl[i].tgt, 0, 0, 32'h0);
      chk($sformatf("tbl%0d_d", i), s_d, tbl[i].d);
      chk($sformatf("tbl%0d_sen", i), {31'b0, s_sen}, {31'b0, tbl[i].sen});
      chk($sformatf("tbl%0d_rp", i), {31'b0, s_rp}, {31'b0, tbl[i].rp});
      if (tbl[i].ck_cnt) chk($sformatf("tbl%0d_cnt", i), s_cnt, tbl[i].cnt);
    end
    chk("pc_after_reset_pend", m_pc, 32'h0000_3004);

    // Exception while a redirect is pending under stall.
    cycle(0, 1, 1, 32'h3200, 0, 0, 32'h0);
    cycle(0, 1, 0, 32'h0, 1, 0, 32'h0);
    chk("exc_d", s_d, EXC_ON ? 32'h0000_4180 : 32'h0000_3200);
    chk("exc_flush", {31'b0, s_flush}, {31'b0, EXC_ON});
    chk("exc_sen", {31'b0, s_sen}, {31'b0, !EXC_ON});
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("exc_rp_after", {31'b0, s_rp}, {31'b0, !EXC_ON});
    if (EXC_ON) chk("exc_pc", m_pc, 32'h0000_4184);

    // ERET concurrent with a branch.
    cycle(0, 0, 1, 32'h3300, 0, 1, 32'h3024);
    chk("eret_d", s_d, EXC_ON ? 32'h0000_3024 : 32'h0000_3300);
    chk("eret_flush", {31'b0, s_flush}, {31'b0, EXC_ON});

    // Sequential wrap at the top of the address space.
    cycle(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("wrap_d", s_d, 32'h0);

    // Long stall saturates the 4-bit counter.
    cycle(1, 0, 0, 32'h0, 0, 0, 32'h0);
    for (int i = 0; i < 18; i++) cycle(0, 1, 0, 32'h0, 0, 0, 32'h0);
    cycle(0, 0, 0, 32'h0, 0, 0, 32'h0);
    chk("sat_cnt4", {28'b0, s_cnt_s}, 32'hF);
    chk("sat_cnt32", s_cnt, 32'd18);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] t;
      t = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 9) < 3, t,
            $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule
